// File: rtl/pipe_hazard_scoreboard.sv
// Hazard-detection and forwarding-control unit beside the ID stage.
// A shift-register scoreboard follows every in-flight register write. Each
// decoded source operand is compared against it, and the unit does one of two
// things: it stalls IF/ID with a bubble into EX, or it issues registered
// forwarding selects for the EX operand muxes.
// Only stages 0..DEPTH-2 are held. The WB stage is never consulted because
// the register file is write-through, so retiring an instruction out of
// stage DEPTH-2 is the same as dropping it.
module pipe_hazard_scoreboard #(
   parameter int AW    = 5,
   parameter int NRD   = 2,
   parameter int DEPTH = 3,
   parameter int SW    = 2,
   parameter int FW    = 2,
   parameter int CW    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [NRD*AW-1:0] id_src,
   input  logic [NRD-1:0]    id_src_used,
   input  logic [AW-1:0]     id_dst,
   input  logic              id_wen,
   input  logic [SW-1:0]     id_rdy_stage,
   input  logic              flush,
   output logic              stall,
   output logic [NRD*FW-1:0] fwd_sel,
   output logic              ex_valid,
   output logic [CW-1:0]     stall_count
);

   localparam int NE = DEPTH - 1;

   logic [NE-1:0]     sb_valid;
   logic [AW-1:0]     sb_dst [NE];
   logic [SW-1:0]     sb_rdy [NE];
   logic [NRD-1:0]    op_hazard;
   logic [NRD*FW-1:0] fwd_next;
   logic              issue;

   for (genvar gi = 0; gi < NRD; gi++) begin : g_op
      logic [AW-1:0] src;
      logic [FW-1:0] sel;
      logic          hz;

      assign src = id_src[gi*AW +: AW];

      // Scan from oldest to youngest so that the youngest matching producer decides the outcome.
      always_comb begin
         sel = '0;
         hz  = 1'b0;
         for (int k = NE - 1; k >= 0; k--) begin
            if (sb_valid[k] && (sb_dst[k] == src) && (src != '0) && id_src_used[gi]) begin
               sel = FW'(k + 1);
               hz  = (SW'(k) < sb_rdy[k]);
            end
         end
      end

      assign op_hazard[gi]            = hz;
      assign fwd_next[gi*FW +: FW]    = hz ? '0 : sel;
   end

   assign stall = id_valid & ~flush & (|op_hazard);
   assign issue = id_valid & ~flush & ~stall;

   // Advance the scoreboard one stage per cycle and push the issuing writer (or a bubble) into EX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_valid <= '0;
         for (int k = 0; k < NE; k++) begin
            sb_dst[k] <= '0;
            sb_rdy[k] <= '0;
         end
      end else begin
         for (int k = NE - 1; k > 0; k--) begin
            sb_valid[k] <= sb_valid[k-1];
            sb_dst[k]   <= sb_dst[k-1];
            sb_rdy[k]   <= sb_rdy[k-1];
         end
         sb_valid[0] <= issue & id_wen & (id_dst != '0);
         sb_dst[0]   <= id_dst;
         sb_rdy[0]   <= id_rdy_stage;
      end
   end

   // Register the forwarding selects and the EX valid bit so that both line up with the instruction's EX cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_sel  <= '0;
         ex_valid <= 1'b0;
      end else if (issue) begin
         fwd_sel  <= fwd_next;
         ex_valid <= 1'b1;
      end else begin
         fwd_sel  <= '0;
         ex_valid <= 1'b0;
      end
   end

   // Count stall cycles, holding at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + CW'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Self-checking bench for pipe_hazard_scoreboard.
// The reference model keeps a timestamped history of issued writers. A
// producer's current stage is taken from its age in cycles. A compare process
// checks every output against that model on each falling edge. Directed
// scenarios add hand-computed literal expectations.
module tb_pipe_hazard_scoreboard;

   localparam int AW    = 5;
   localparam int NRD   = 2;
   localparam int DEPTH = 3;
   localparam int SW    = 2;
   localparam int FW    = 2;
   localparam int CW    = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              id_valid;
   logic [NRD*AW-1:0] id_src;
   logic [NRD-1:0]    id_src_used;
   logic [AW-1:0]     id_dst;
   logic              id_wen;
   logic [SW-1:0]     id_rdy_stage;
   logic              flush;
   logic              stall;
   logic [NRD*FW-1:0] fwd_sel;
   logic              ex_valid;
   logic [CW-1:0]     stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   int            cyc;
   int            h_cyc [$];
   logic [AW-1:0] h_dst [$];
   int            h_rdy [$];
   logic [NRD*FW-1:0] m_fwd;
   logic              m_exv;
   logic [CW-1:0]     m_cnt;

   pipe_hazard_scoreboard #(
      .AW(AW), .NRD(NRD), .DEPTH(DEPTH), .SW(SW), .FW(FW), .CW(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .id_valid(id_valid),
      .id_src(id_src),
      .id_src_used(id_src_used),
      .id_dst(id_dst),
      .id_wen(id_wen),
      .id_rdy_stage(id_rdy_stage),
      .flush(flush),
      .stall(stall),
      .fwd_sel(fwd_sel),
      .ex_valid(ex_valid),
      .stall_count(stall_count)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // For each operand, find the youngest writer whose age puts it in stage 0..DEPTH-2.
   // The result is a hazard if that writer's result is not ready yet; otherwise it is a forwarding select.
   function automatic void modelEval(output logic hz_any, output logic [NRD*FW-1:0] sel);
      hz_any = 1'b0;
      sel    = '0;
      for (int i = 0; i < NRD; i++) begin
         logic [AW-1:0] src;
         bit found;
         int best_c, best_age, best_rdy;
         src = id_src[i*AW +: AW];
         found = 0; best_c = 0; best_age = 0; best_rdy = 0;
         if (id_src_used[i] && src != '0) begin
            for (int j = 0; j < h_cyc.size(); j++) begin
               int age;
               age = cyc - h_cyc[j] - 1;
               if (h_dst[j] == src && age >= 0 && age <= DEPTH - 2 && (!found || h_cyc[j] > best_c)) begin
                  found    = 1;
                  best_c   = h_cyc[j];
                  best_age = age;
                  best_rdy = h_rdy[j];
               end
            end
         end
         if (found) begin
            if (best_age < best_rdy) hz_any = 1'b1;
            else sel[i*FW +: FW] = FW'(best_age + 1);
         end
      end
      if (hz_any) sel = '0;
   endfunction

   // Advance the reference model on each clock edge; reset wipes the history.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0;
         h_cyc.delete();
         h_dst.delete();
         h_rdy.delete();
         m_fwd = '0;
         m_exv = 1'b0;
         m_cnt = '0;
      end else begin
         logic hz;
         logic [NRD*FW-1:0] sel;
         logic st, iss;
         modelEval(hz, sel);
         st  = id_valid & ~flush & hz;
         iss = id_valid & ~flush & ~hz;
         if (st && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
         m_exv = iss;
         m_fwd = iss ? sel : '0;
         if (iss && id_wen && id_dst != '0) begin
            h_cyc.push_back(cyc);
            h_dst.push_back(id_dst);
            h_rdy.push_back(int'(id_rdy_stage));
         end
         cyc++;
      end
   end

   // On every falling edge, compare all DUT outputs against the model.
   always @(negedge clk) begin
      logic hz;
      logic [NRD*FW-1:0] sel;
      modelEval(hz, sel);
      checkOutput("model_stall", stall, id_valid & ~flush & hz);
      checkOutput("model_fwd_sel", fwd_sel, m_fwd);
      checkOutput("model_ex_valid", ex_valid, m_exv);
      checkOutput("model_stall_count", stall_count, m_cnt);
   end

   task automatic applyStimulus(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                                input logic [1:0] used, input logic [AW-1:0] dst, input logic wen,
                                input logic [SW-1:0] rdy, input logic fl);
      @(posedge clk);
      #1;
      id_valid     = v;
      id_src       = {s1, s0};
      id_src_used  = used;
      id_dst       = dst;
      id_wen       = wen;
      id_rdy_stage = rdy;
      flush        = fl;
      @(negedge clk);
   endtask

   task automatic bubble();
      applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0);
   endtask

   // Directed scenarios with hand-computed literal expectations.
   initial begin
      rst_n = 1'b0;
      id_valid = 1'b0; id_src = '0; id_src_used = '0; id_dst = '0;
      id_wen = 1'b0; id_rdy_stage = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_fwd_sel", fwd_sel, 0);
      checkOutput("reset_ex_valid", ex_valid, 0);
      checkOutput("reset_stall_count", stall_count, 0);
      rst_n = 1'b1;

      $display("[TB] ALU forward");
      applyStimulus(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 2'd0, 0);
      checkOutput("alu_prod_stall", stall, 0);
      applyStimulus(1, 5'd3, 5'd0, 2'b01, 5'd6, 1, 2'd0, 0);
      checkOutput("alu_cons_stall", stall, 0);
      bubble();
      checkOutput("alu_fwd_sel", fwd_sel, 4'b0001);
      checkOutput("alu_ex_valid", ex_valid, 1);
      bubble();

      $display("[TB] Load-use");
      applyStimulus(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 2'd1, 0);
      applyStimulus(1, 5'd1, 5'd5, 2'b11, 5'd8, 1, 2'd0, 0);
      checkOutput("lu_stall_first", stall, 1);
      applyStimulus(1, 5'd1, 5'd5, 2'b11, 5'd8, 1, 2'd0, 0);
      checkOutput("lu_stall_second", stall, 0);
      bubble();
      checkOutput("lu_fwd_sel", fwd_sel, 4'b1000);
      checkOutput("lu_ex_valid", ex_valid, 1);
      checkOutput("lu_stall_count", stall_count, 1);
      bubble();

      $display("[TB] Youngest wins, r0, unused operand");
      applyStimulus(1, 5'd0, 5'd0, 2'b00, 5'd4, 1, 2'd0, 0);
      applyStimulus(1, 5'd0, 5'd0, 2'b00, 5'd4, 1, 2'd0, 0);
      applyStimulus(1, 5'd4, 5'd0, 2'b01, 5'd0, 0, 2'd0, 0);
      bubble();
      checkOutput("young_fwd_sel", fwd_sel, 4'b0001);
      applyStimulus(1, 5'd0, 5'd0, 2'b00, 5'd0, 1, 2'd1, 0);
      applyStimulus(1, 5'd0, 5'd0, 2'b11, 5'd0, 0, 2'd0, 0);
      checkOutput("r0_stall", stall, 0);
      bubble();
      checkOutput("r0_fwd_sel", fwd_sel, 0);
      checkOutput("r0_ex_valid", ex_valid, 1);
      applyStimulus(1, 5'd0, 5'd0, 2'b00, 5'd10, 1, 2'd0, 0);
      applyStimulus(1, 5'd10, 5'd10, 2'b00, 5'd0, 0, 2'd0, 0);
      bubble();
      checkOutput("unused_fwd_sel", fwd_sel, 0);
      checkOutput("unused_ex_valid", ex_valid, 1);

      $display("[TB] Distance and WB");
      applyStimulus(1, 5'd0, 5'd0, 2'b00, 5'd7, 1, 2'd1, 0);
      applyStimulus(1, 5'd1, 5'd2, 2'b11, 5'd0, 0, 2'd0, 0);
      applyStimulus(1, 5'd1, 5'd2, 2'b11, 5'd0, 0, 2'd0, 0);
      applyStimulus(1, 5'd0, 5'd7, 2'b10, 5'd0, 0, 2'd0, 0);
      checkOutput("wb_stall", stall, 0);
      bubble();
      checkOutput("wb_fwd_sel", fwd_sel, 0);
      applyStimulus(1, 5'd0, 5'd0, 2'b00, 5'd11, 1, 2'd1, 0);
      applyStimulus(1, 5'd1, 5'd2, 2'b11, 5'd0, 0, 2'd0, 0);
      applyStimulus(1, 5'd11, 5'd0, 2'b01, 5'd0, 0, 2'd0, 0);
      checkOutput("mem_dist_stall", stall, 0);
      bubble();
      checkOutput("mem_dist_fwd_sel", fwd_sel, 4'b0010);
      bubble();

      $display("[TB] Flush");
      applyStimulus(1, 5'd0, 5'd0, 2'b00, 5'd12, 1, 2'd1, 0);
      applyStimulus(1, 5'd12, 5'd0, 2'b01, 5'd9, 1, 2'd0, 1);
      checkOutput("flush_stall", stall, 0);
      applyStimulus(1, 5'd9, 5'd0, 2'b01, 5'd0, 0, 2'd0, 0);
      checkOutput("flush_ex_valid", ex_valid, 0);
      checkOutput("flush_stall_count", stall_count, 1);
      checkOutput("flush_reader_stall", stall, 0);
      bubble();
      checkOutput("flush_reader_fwd_sel", fwd_sel, 0);
      checkOutput("flush_reader_ex_valid", ex_valid, 1);

      $display("[TB] Reset mid-stall");
      applyStimulus(1, 5'd0, 5'd0, 2'b00, 5'd13, 1, 2'd1, 0);
      applyStimulus(1, 5'd13, 5'd0, 2'b01, 5'd0, 0, 2'd0, 0);
      checkOutput("rst_pre_stall", stall, 1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_fwd_sel", fwd_sel, 0);
      checkOutput("rst_ex_valid", ex_valid, 0);
      checkOutput("rst_count", stall_count, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_release_stall", stall, 0);
      applyStimulus(1, 5'd13, 5'd0, 2'b01, 5'd0, 0, 2'd0, 0);
      checkOutput("rst_after_fwd_sel", fwd_sel, 0);
      checkOutput("rst_after_ex_valid", ex_valid, 1);

      $display("[TB] Stall counter saturation");
      for (int n = 0; n < 8; n++) begin
         applyStimulus(1, 5'd0, 5'd0, 2'b00, 5'd20, 1, 2'd1, 0);
         applyStimulus(1, 5'd20, 5'd0, 2'b01, 5'd0, 0, 2'd0, 0);
         applyStimulus(1, 5'd20, 5'd0, 2'b01, 5'd0, 0, 2'd0, 0);
      end
      bubble();
      checkOutput("sat_stall_count", stall_count, 7);
      bubble();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
